axi_lite_xbar: RTL and testbench
================================

// Module: axi_lite_xbar
// PURPOSE
// - 1-master / 3-slave AXI4-Lite crossbar between the core's LSU bus port and the memory-mapped slaves.
// - Slaves: SRAM (slot 0), UART (slot 1), CLINT (slot 2).
// - Decodes each address, forwards the request to the one selected slave, and routes that slave's response back.
// - Unmapped addresses get an error response generated locally; no slave sees them.
// PARAMETERS
// SRAM_BASE   32'h8000_0000  slot 0 base address
// SRAM_SIZE   32'h0800_0000  slot 0 size in bytes
// UART_BASE   32'ha000_03f8  slot 1 base address
// UART_SIZE   32'h0000_0008  slot 1 size in bytes
// CLINT_BASE  32'ha000_0048  slot 2 base address
// CLINT_SIZE  32'h0000_0008  slot 2 size in bytes
// PORTS
// clk    input  1     clock
// reset  input  1     reset, synchronous, active-high
// m      axi_lite_if.slave   intf  upstream master (LSU)
// s0     axi_lite_if.master  intf  SRAM slave
// s1     axi_lite_if.master  intf  UART slave
// s2     axi_lite_if.master  intf  CLINT slave
// BEHAVIOUR
// - Decode: slot k hits when BASE_k <= addr < BASE_k+SIZE_k, compared as 33-bit unsigned (no wrap). No hit = DECERR.
// - Read and write paths are independent FSMs. Each path allows at most 1 outstanding transaction.
// - Read FSM states: RD_IDLE, RD_FWD, RD_RESP, RD_ERR.
//   - RD_IDLE: m.arready=1. On AR handshake, latch araddr and the decoded slot.
//     Next state: RD_FWD on a hit, RD_ERR on a miss.
//   - RD_FWD: sel.arvalid=1, carrying the latched araddr. Stay until sel.arready, then go to RD_RESP.
//     A request reaches the slave 1 cycle after the master handshake.
//   - RD_RESP: combinational pass-through: m.rvalid/rdata/rresp = sel's; sel.rready = m.rready.
//     On m.rvalid && m.rready, go to RD_IDLE.
//   - RD_ERR: m.rvalid=1, rdata=0, rresp=all-ones. Hold until m.rready, then go to RD_IDLE.
// - Write FSM states: WR_IDLE, WR_FWD, WR_RESP, WR_ERR.
//   - WR_IDLE: awready = !aw_got; wready = !w_got.
//     AW and W may arrive in the same cycle or in either order. Latch each payload and set aw_got / w_got.
//     When both flags are set (counting a same-cycle set), decode the latched awaddr.
//     Next state: WR_FWD on a hit, WR_ERR on a miss. Clear both flags.
//   - WR_FWD: sel.awvalid = !aw_done and sel.wvalid = !w_done, each with the latched payload.
//     The done flags are set independently on each slave handshake. When both are done, go to WR_RESP.
//   - WR_RESP: pass-through of B: m.bvalid/bresp = sel's; sel.bready = m.bready.
//     On handshake, go to WR_IDLE.
//   - WR_ERR: m.bvalid=1, bresp=all-ones. Hold until m.bready, then go to WR_IDLE.
// - Slave outputs:
//   - Non-selected slaves see every valid/ready signal driven 0.
//   - addr/data pins show the latched value, unchanged, to all slaves.
// - Master outputs: m.rvalid, m.bvalid and all m resp/data are 0 outside RESP/ERR states.
// - Reset (at any point, including mid-transaction):
//   - Both FSMs go to IDLE. aw_got, w_got, aw_done, w_done cleared. Latched slot = 0.
//   - Immediately after reset all slave-side valids are 0, m.arready=1, m.awready=1, m.wready=1.
//   - Nothing in flight is replayed after reset.
// - Payloads are held stable while valid is high and ready is low. valid is never dropped before its handshake.
// - A read to the same slave as an in-flight write is not ordered against it. Slaves handle their channels independently.
// TESTING
// - Write 0x41 to 0xa000_03f8, AW and W in the same cycle:
//   - cycle+1: s1.awvalid=1 with awaddr=0xa000_03f8 and s1.wvalid=1 with wdata=0x41.
//   - s0 and s2 stay idle. s1's bresp=0 is returned on m.
// - W arrives 3 cycles before AW, target 0x8000_0010:
//   - m.wready drops after the W handshake.
//   - s0 gets AW and W only after AW is captured. 1 B is returned on m.
// - Read 0x8000_0004 with s0 returning 0xdeadbeef, and m.rready held low for 4 cycles:
//   - m.rvalid and rdata stay stable during the stall.
//   - Completes to RD_IDLE exactly once.
// - Read 0x0000_0000 and write 0xa000_0400 (both unmapped):
//   - rresp/bresp all-ones, rdata=0.
//   - No valid is asserted on s0, s1 or s2.
// - Concurrent traffic: CLINT read 0xa000_0048 issued in the same cycle as a UART write:
//   - Both complete. Each slave sees only its own channel.
// - reset asserted while in RD_FWD and WR_FWD (s1 holding awready=0):
//   - Next cycle all slave valids are 0, and m.arready=1 and m.awready=1.

Source files
------------

// File: rtl/axi_lite_xbar_if.sv
// AXI4-Lite channel bundle shared by the LSU port and the memory-mapped slaves.
interface axi_lite_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_xbar.sv
// 1-master / 3-slave AXI4-Lite crossbar (SRAM, UART, CLINT) with local DECERR for unmapped addresses.
module axi_lite_xbar #(
    parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
    parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
    parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
    input logic         clk,
    input logic         reset,
    axi_lite_if.slave   m,
    axi_lite_if.master  s0,
    axi_lite_if.master  s1,
    axi_lite_if.master  s2
);

    localparam int unsigned NS     = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_RESP, RD_ERR} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP, WR_ERR} wr_state_e;

    // Returns a one-hot slot select; all zeros means no slave claims the address.
    function automatic logic [NS-1:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] a;
        a = {1'b0, addr};
        decode = '0;
        if (a >= (ADDR_W+1)'(SRAM_BASE) && a < (ADDR_W+1)'(SRAM_BASE) + (ADDR_W+1)'(SRAM_SIZE))
            decode = 3'b001;
        else if (a >= (ADDR_W+1)'(UART_BASE) && a < (ADDR_W+1)'(UART_BASE) + (ADDR_W+1)'(UART_SIZE))
            decode = 3'b010;
        else if (a >= (ADDR_W+1)'(CLINT_BASE) && a < (ADDR_W+1)'(CLINT_BASE) + (ADDR_W+1)'(CLINT_SIZE))
            decode = 3'b100;
    endfunction

    // Slave-side inputs gathered into vectors indexed by slot.
    logic [NS-1:0]     s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DATA_W-1:0] s_rdata [NS];
    logic [RESP_W-1:0] s_rresp [NS];
    logic [RESP_W-1:0] s_bresp [NS];

    assign s_arready = {s2.arready, s1.arready, s0.arready};
    assign s_rvalid  = {s2.rvalid,  s1.rvalid,  s0.rvalid};
    assign s_awready = {s2.awready, s1.awready, s0.awready};
    assign s_wready  = {s2.wready,  s1.wready,  s0.wready};
    assign s_bvalid  = {s2.bvalid,  s1.bvalid,  s0.bvalid};
    assign s_rdata[0] = s0.rdata;
    assign s_rdata[1] = s1.rdata;
    assign s_rdata[2] = s2.rdata;
    assign s_rresp[0] = s0.rresp;
    assign s_rresp[1] = s1.rresp;
    assign s_rresp[2] = s2.rresp;
    assign s_bresp[0] = s0.bresp;
    assign s_bresp[1] = s1.bresp;
    assign s_bresp[2] = s2.bresp;

    // ---------------- read path ----------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [NS-1:0]     rd_sel_q, rd_sel_d;

    logic              m_arready_c, m_rvalid_c;
    logic [DATA_W-1:0] m_rdata_c;
    logic [RESP_W-1:0] m_rresp_c;
    logic [NS-1:0]     s_arvalid_c, s_rready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_sel_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_addr_d   = rd_addr_q;
        rd_sel_d    = rd_sel_q;
        m_arready_c = 1'b0;
        m_rvalid_c  = 1'b0;
        m_rdata_c   = '0;
        m_rresp_c   = '0;
        s_arvalid_c = '0;
        s_rready_c  = '0;
        case (rd_state_q)
            RD_IDLE: begin
                m_arready_c = 1'b1;
                if (m.arvalid) begin
                    rd_addr_d  = m.araddr;
                    rd_sel_d   = decode(m.araddr);
                    rd_state_d = (decode(m.araddr) != '0) ? RD_FWD : RD_ERR;
                end
            end
            RD_FWD: begin
                s_arvalid_c = rd_sel_q;
                if ((rd_sel_q & s_arready) != '0) rd_state_d = RD_RESP;
            end
            RD_RESP: begin
                for (int k = 0; k < NS; k++) begin
                    if (rd_sel_q[k]) begin
                        m_rvalid_c = s_rvalid[k];
                        m_rdata_c  = s_rdata[k];
                        m_rresp_c  = s_rresp[k];
                    end
                end
                s_rready_c = rd_sel_q & {NS{m.rready}};
                if (m_rvalid_c && m.rready) rd_state_d = RD_IDLE;
            end
            RD_ERR: begin
                m_rvalid_c = 1'b1;
                m_rresp_c  = RESP_DECERR;
                if (m.rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // ---------------- write path ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic [NS-1:0]     wr_sel_q, wr_sel_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic              m_awready_c, m_wready_c, m_bvalid_c;
    logic [RESP_W-1:0] m_bresp_c;
    logic [NS-1:0]     s_awvalid_c, s_wvalid_c, s_bready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_sel_q   <= '0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_sel_q   <= wr_sel_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        wr_sel_d    = wr_sel_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        m_awready_c = 1'b0;
        m_wready_c  = 1'b0;
        m_bvalid_c  = 1'b0;
        m_bresp_c   = '0;
        s_awvalid_c = '0;
        s_wvalid_c  = '0;
        s_bready_c  = '0;
        case (wr_state_q)
            WR_IDLE: begin
                m_awready_c = !aw_got_q;
                m_wready_c  = !w_got_q;
                if (m.awvalid && !aw_got_q) begin
                    aw_addr_d = m.awaddr;
                    aw_got_d  = 1'b1;
                end
                if (m.wvalid && !w_got_q) begin
                    w_data_d = m.wdata;
                    w_strb_d = m.wstrb;
                    w_got_d  = 1'b1;
                end
                // Dispatch once both halves are held, including a same-cycle arrival.
                if (aw_got_d && w_got_d) begin
                    wr_sel_d   = decode(aw_addr_d);
                    wr_state_d = (decode(aw_addr_d) != '0) ? WR_FWD : WR_ERR;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WR_FWD: begin
                s_awvalid_c = aw_done_q ? '0 : wr_sel_q;
                s_wvalid_c  = w_done_q  ? '0 : wr_sel_q;
                if ((s_awvalid_c & s_awready) != '0) aw_done_d = 1'b1;
                if ((s_wvalid_c & s_wready) != '0)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = WR_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WR_RESP: begin
                for (int k = 0; k < NS; k++) begin
                    if (wr_sel_q[k]) begin
                        m_bvalid_c = s_bvalid[k];
                        m_bresp_c  = s_bresp[k];
                    end
                end
                s_bready_c = wr_sel_q & {NS{m.bready}};
                if (m_bvalid_c && m.bready) wr_state_d = WR_IDLE;
            end
            WR_ERR: begin
                m_bvalid_c = 1'b1;
                m_bresp_c  = RESP_DECERR;
                if (m.bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // ---------------- port drive ----------------
    assign m.arready = m_arready_c;
    assign m.rvalid  = m_rvalid_c;
    assign m.rdata   = m_rdata_c;
    assign m.rresp   = m_rresp_c;
    assign m.awready = m_awready_c;
    assign m.wready  = m_wready_c;
    assign m.bvalid  = m_bvalid_c;
    assign m.bresp   = m_bresp_c;

    assign s0.araddr  = rd_addr_q;
    assign s0.arvalid = s_arvalid_c[0];
    assign s0.rready  = s_rready_c[0];
    assign s0.awaddr  = aw_addr_q;
    assign s0.awvalid = s_awvalid_c[0];
    assign s0.wdata   = w_data_q;
    assign s0.wstrb   = w_strb_q;
    assign s0.wvalid  = s_wvalid_c[0];
    assign s0.bready  = s_bready_c[0];

    assign s1.araddr  = rd_addr_q;
    assign s1.arvalid = s_arvalid_c[1];
    assign s1.rready  = s_rready_c[1];
    assign s1.awaddr  = aw_addr_q;
    assign s1.awvalid = s_awvalid_c[1];
    assign s1.wdata   = w_data_q;
    assign s1.wstrb   = w_strb_q;
    assign s1.wvalid  = s_wvalid_c[1];
    assign s1.bready  = s_bready_c[1];

    assign s2.araddr  = rd_addr_q;
    assign s2.arvalid = s_arvalid_c[2];
    assign s2.rready  = s_rready_c[2];
    assign s2.awaddr  = aw_addr_q;
    assign s2.awvalid = s_awvalid_c[2];
    assign s2.wdata   = w_data_q;
    assign s2.wstrb   = w_strb_q;
    assign s2.wvalid  = s_wvalid_c[2];
    assign s2.bready  = s_bready_c[2];

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: LSU-side master tasks plus three simple responding slaves.
module tb_axi_lite_xbar;

    logic clk;
    logic reset;

    axi_lite_if m_if ();
    axi_lite_if s_if0 ();
    axi_lite_if s_if1 ();
    axi_lite_if s_if2 ();

    axi_lite_xbar dut (
        .clk   (clk),
        .reset (reset),
        .m     (m_if),
        .s0    (s_if0),
        .s1    (s_if1),
        .s2    (s_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave models: one-cycle response, programmable AW/AR ready, handshake counters.
    logic [2:0]  sl_aw_rdy_en = 3'b111;
    logic [2:0]  sl_ar_rdy_en = 3'b111;
    logic [2:0]  sl_bvalid, sl_rvalid, got_aw, got_w;
    logic [31:0] sl_rdata_cfg [3];
    int          aw_cnt [3] = '{0, 0, 0};
    int          w_cnt  [3] = '{0, 0, 0};
    int          ar_cnt [3] = '{0, 0, 0};
    int          vld_cyc[3] = '{0, 0, 0};
    logic [31:0] last_awaddr [3], last_wdata [3], last_araddr [3];

    logic [2:0]  o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready;
    logic [31:0] o_awaddr [3], o_wdata [3], o_araddr [3];

    assign o_awvalid = {s_if2.awvalid, s_if1.awvalid, s_if0.awvalid};
    assign o_wvalid  = {s_if2.wvalid,  s_if1.wvalid,  s_if0.wvalid};
    assign o_arvalid = {s_if2.arvalid, s_if1.arvalid, s_if0.arvalid};
    assign o_bready  = {s_if2.bready,  s_if1.bready,  s_if0.bready};
    assign o_rready  = {s_if2.rready,  s_if1.rready,  s_if0.rready};
    assign o_awaddr[0] = s_if0.awaddr;
    assign o_awaddr[1] = s_if1.awaddr;
    assign o_awaddr[2] = s_if2.awaddr;
    assign o_wdata[0]  = s_if0.wdata;
    assign o_wdata[1]  = s_if1.wdata;
    assign o_wdata[2]  = s_if2.wdata;
    assign o_araddr[0] = s_if0.araddr;
    assign o_araddr[1] = s_if1.araddr;
    assign o_araddr[2] = s_if2.araddr;

    assign s_if0.awready = sl_aw_rdy_en[0];
    assign s_if0.wready  = 1'b1;
    assign s_if0.arready = sl_ar_rdy_en[0];
    assign s_if0.bvalid  = sl_bvalid[0];
    assign s_if0.bresp   = 2'b00;
    assign s_if0.rvalid  = sl_rvalid[0];
    assign s_if0.rdata   = sl_rdata_cfg[0];
    assign s_if0.rresp   = 2'b00;
    assign s_if1.awready = sl_aw_rdy_en[1];
    assign s_if1.wready  = 1'b1;
    assign s_if1.arready = sl_ar_rdy_en[1];
    assign s_if1.bvalid  = sl_bvalid[1];
    assign s_if1.bresp   = 2'b00;
    assign s_if1.rvalid  = sl_rvalid[1];
    assign s_if1.rdata   = sl_rdata_cfg[1];
    assign s_if1.rresp   = 2'b00;
    assign s_if2.awready = sl_aw_rdy_en[2];
    assign s_if2.wready  = 1'b1;
    assign s_if2.arready = sl_ar_rdy_en[2];
    assign s_if2.bvalid  = sl_bvalid[2];
    assign s_if2.bresp   = 2'b00;
    assign s_if2.rvalid  = sl_rvalid[2];
    assign s_if2.rdata   = sl_rdata_cfg[2];
    assign s_if2.rresp   = 2'b00;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                got_aw[k]    <= 1'b0;
                got_w[k]     <= 1'b0;
                sl_bvalid[k] <= 1'b0;
                sl_rvalid[k] <= 1'b0;
            end else begin
                if (o_awvalid[k] || o_wvalid[k] || o_arvalid[k]) vld_cyc[k] <= vld_cyc[k] + 1;
                if (o_awvalid[k] && sl_aw_rdy_en[k]) begin
                    aw_cnt[k]      <= aw_cnt[k] + 1;
                    last_awaddr[k] <= o_awaddr[k];
                    got_aw[k]      <= 1'b1;
                end
                if (o_wvalid[k]) begin
                    w_cnt[k]      <= w_cnt[k] + 1;
                    last_wdata[k] <= o_wdata[k];
                    got_w[k]      <= 1'b1;
                end
                if (got_aw[k] && got_w[k] && !sl_bvalid[k]) begin
                    sl_bvalid[k] <= 1'b1;
                    got_aw[k]    <= 1'b0;
                    got_w[k]     <= 1'b0;
                end else if (sl_bvalid[k] && o_bready[k]) begin
                    sl_bvalid[k] <= 1'b0;
                end
                if (o_arvalid[k] && sl_ar_rdy_en[k]) begin
                    ar_cnt[k]      <= ar_cnt[k] + 1;
                    last_araddr[k] <= o_araddr[k];
                    sl_rvalid[k]   <= 1'b1;
                end else if (sl_rvalid[k] && o_rready[k]) begin
                    sl_rvalid[k] <= 1'b0;
                end
            end
        end
    end

    int r_hs = 0;
    int b_hs = 0;
    always @(posedge clk) begin
        if (!reset && m_if.rvalid && m_if.rready) r_hs <= r_hs + 1;
        if (!reset && m_if.bvalid && m_if.bready) b_hs <= b_hs + 1;
    end

    // Master-side tasks; all driving and sampling happens on the falling edge.
    task automatic wr_req(input logic [31:0] addr, input logic [31:0] data);
        m_if.awaddr  = addr;
        m_if.awvalid = 1'b1;
        m_if.wdata   = data;
        m_if.wstrb   = 4'hf;
        m_if.wvalid  = 1'b1;
        #1;
        check("wr_req_awready", 32'(m_if.awready), 32'd1);
        check("wr_req_wready", 32'(m_if.wready), 32'd1);
        @(negedge clk);
        m_if.awvalid = 1'b0;
        m_if.wvalid  = 1'b0;
    endtask

    task automatic rd_req(input logic [31:0] addr);
        m_if.araddr  = addr;
        m_if.arvalid = 1'b1;
        #1;
        check("rd_req_arready", 32'(m_if.arready), 32'd1);
        @(negedge clk);
        m_if.arvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int   n;
        logic to;
        n = 0;
        m_if.bready = 1'b1;
        while (!m_if.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 20);
        check("b_timeout", 32'(to), 32'd0);
        resp = m_if.bresp;
        @(negedge clk);
        m_if.bready = 1'b0;
    endtask

    task automatic wait_r(input int stall, input logic [31:0] exp_data,
                          output logic [31:0] data, output logic [1:0] resp);
        int   n;
        logic to;
        n = 0;
        m_if.rready = 1'b0;
        while (!m_if.rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 20);
        check("r_timeout", 32'(to), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("r_stall_valid", 32'(m_if.rvalid), 32'd1);
            check("r_stall_data", m_if.rdata, exp_data);
        end
        m_if.rready = 1'b1;
        data = m_if.rdata;
        resp = m_if.rresp;
        @(negedge clk);
        m_if.rready = 1'b0;
    endtask

    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          snap_a, snap_b, snap_c, snap_d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sl_rdata_cfg[0] = 32'hdead_beef;
        sl_rdata_cfg[1] = 32'h0000_00a5;
        sl_rdata_cfg[2] = 32'h1234_5678;
        m_if.awaddr = '0; m_if.awvalid = 1'b0; m_if.wdata = '0; m_if.wstrb = '0;
        m_if.wvalid = 1'b0; m_if.bready = 1'b0; m_if.araddr = '0; m_if.arvalid = 1'b0;
        m_if.rready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_arready", 32'(m_if.arready), 32'd1);
        check("rst_awready", 32'(m_if.awready), 32'd1);
        check("rst_wready", 32'(m_if.wready), 32'd1);
        check("rst_mvalid", 32'({m_if.rvalid, m_if.bvalid}), 32'd0);
        check("rst_svalid", 32'({o_awvalid, o_wvalid, o_arvalid}), 32'd0);

        // UART write, AW and W together
        snap_a = vld_cyc[0] + vld_cyc[2];
        snap_b = b_hs;
        wr_req(32'ha000_03f8, 32'h41);
        check("t1_awvalid", 32'(o_awvalid), 32'b010);
        check("t1_wvalid", 32'(o_wvalid), 32'b010);
        check("t1_awaddr", o_awaddr[1], 32'ha000_03f8);
        check("t1_wdata", o_wdata[1], 32'h41);
        wait_b(bresp);
        check("t1_bresp", 32'(bresp), 32'd0);
        check("t1_bhs", 32'(b_hs - snap_b), 32'd1);
        check("t1_others_idle", 32'(vld_cyc[0] + vld_cyc[2] - snap_a), 32'd0);
        check("t1_s1_awcnt", 32'(aw_cnt[1]), 32'd1);

        // SRAM write, W three cycles ahead of AW
        snap_b = b_hs;
        m_if.wdata  = 32'h5555_aaaa;
        m_if.wstrb  = 4'hf;
        m_if.wvalid = 1'b1;
        #1;
        check("t2_wready_pre", 32'(m_if.wready), 32'd1);
        @(negedge clk);
        m_if.wvalid = 1'b0;
        check("t2_wready_drop", 32'(m_if.wready), 32'd0);
        check("t2_awready_hold", 32'(m_if.awready), 32'd1);
        repeat (2) @(negedge clk);
        check("t2_s0_quiet", 32'({o_awvalid[0], o_wvalid[0]}), 32'd0);
        check("t2_s0_wcnt", 32'(w_cnt[0]), 32'd0);
        m_if.awaddr  = 32'h8000_0010;
        m_if.awvalid = 1'b1;
        #1;
        check("t2_awready", 32'(m_if.awready), 32'd1);
        @(negedge clk);
        m_if.awvalid = 1'b0;
        check("t2_fwd_valids", 32'({o_awvalid[0], o_wvalid[0]}), 32'b11);
        check("t2_fwd_wdata", o_wdata[0], 32'h5555_aaaa);
        wait_b(bresp);
        repeat (3) @(negedge clk);
        check("t2_bresp", 32'(bresp), 32'd0);
        check("t2_bhs_once", 32'(b_hs - snap_b), 32'd1);
        check("t2_s0_awaddr", last_awaddr[0], 32'h8000_0010);
        check("t2_s0_wdata", last_wdata[0], 32'h5555_aaaa);

        // SRAM read with a 4-cycle master stall
        snap_b = r_hs;
        rd_req(32'h8000_0004);
        wait_r(4, 32'hdead_beef, rdata, rresp);
        repeat (2) @(negedge clk);
        check("t3_rdata", rdata, 32'hdead_beef);
        check("t3_rresp", 32'(rresp), 32'd0);
        check("t3_rhs_once", 32'(r_hs - snap_b), 32'd1);
        check("t3_idle", 32'({m_if.arready, m_if.rvalid}), 32'b10);
        check("t3_s0_araddr", last_araddr[0], 32'h8000_0004);
        check("t3_s0_arcnt", 32'(ar_cnt[0]), 32'd1);

        // Unmapped read/write plus range edges
        snap_a = vld_cyc[0] + vld_cyc[1] + vld_cyc[2];
        rd_req(32'h0000_0000);
        wait_r(0, 32'h0, rdata, rresp);
        check("t4_rd0_rresp", 32'(rresp), 32'd3);
        check("t4_rd0_rdata", rdata, 32'h0);
        wr_req(32'ha000_0400, 32'h99);
        wait_b(bresp);
        check("t4_wr_bresp", 32'(bresp), 32'd3);
        rd_req(32'h8800_0000);
        wait_r(0, 32'h0, rdata, rresp);
        check("t4_sram_end_rresp", 32'(rresp), 32'd3);
        rd_req(32'ha000_0050);
        wait_r(0, 32'h0, rdata, rresp);
        check("t4_clint_end_rresp", 32'(rresp), 32'd3);
        check("t4_no_slave_valid", 32'(vld_cyc[0] + vld_cyc[1] + vld_cyc[2] - snap_a), 32'd0);
        rd_req(32'ha000_03ff);
        wait_r(0, 32'h0000_00a5, rdata, rresp);
        check("t4_uart_last_rdata", rdata, 32'h0000_00a5);
        check("t4_uart_last_rresp", 32'(rresp), 32'd0);

        // Concurrent CLINT read and UART write
        snap_a = ar_cnt[2]; snap_b = aw_cnt[2]; snap_c = aw_cnt[1]; snap_d = ar_cnt[1];
        fork
            begin
                wr_req(32'ha000_03f8, 32'h7e);
                wait_b(bresp);
            end
            begin
                rd_req(32'ha000_0048);
                wait_r(0, 32'h1234_5678, rdata, rresp);
            end
        join
        check("t5_bresp", 32'(bresp), 32'd0);
        check("t5_rdata", rdata, 32'h1234_5678);
        check("t5_rresp", 32'(rresp), 32'd0);
        check("t5_s2_ar", 32'(ar_cnt[2] - snap_a), 32'd1);
        check("t5_s2_aw", 32'(aw_cnt[2] - snap_b), 32'd0);
        check("t5_s1_aw", 32'(aw_cnt[1] - snap_c), 32'd1);
        check("t5_s1_ar", 32'(ar_cnt[1] - snap_d), 32'd0);
        check("t5_s1_wdata", last_wdata[1], 32'h7e);

        // Reset while both paths are stuck forwarding to UART
        sl_aw_rdy_en[1] = 1'b0;
        sl_ar_rdy_en[1] = 1'b0;
        fork
            wr_req(32'ha000_03fc, 32'h11);
            rd_req(32'ha000_03f8);
        join
        check("t6_fwd_aw", 32'(o_awvalid[1]), 32'd1);
        check("t6_fwd_ar", 32'(o_arvalid[1]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_svalid_clear", 32'({o_awvalid, o_wvalid, o_arvalid}), 32'd0);
        check("t6_arready", 32'(m_if.arready), 32'd1);
        check("t6_awready", 32'(m_if.awready), 32'd1);
        check("t6_wready", 32'(m_if.wready), 32'd1);
        reset = 1'b0;
        sl_aw_rdy_en[1] = 1'b1;
        sl_ar_rdy_en[1] = 1'b1;
        snap_a = vld_cyc[1]; snap_b = aw_cnt[1]; snap_c = ar_cnt[1];
        repeat (5) @(negedge clk);
        check("t6_no_replay_vld", 32'(vld_cyc[1] - snap_a), 32'd0);
        check("t6_no_replay_aw", 32'(aw_cnt[1] - snap_b), 32'd0);
        check("t6_no_replay_ar", 32'(ar_cnt[1] - snap_c), 32'd0);
        wr_req(32'ha000_03f8, 32'h22);
        wait_b(bresp);
        check("t6_after_bresp", 32'(bresp), 32'd0);
        check("t6_after_wdata", last_wdata[1], 32'h22);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
